id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS datapath.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards against the EX/MEM and MEM/WB stages.
- Drives the ALU inputs i1, i2, op and sa directly. Handles stall (hold) and flush (bubble).

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants, forwarding encodings and the ID/EX stage record.
package cpu_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [2:0]    alu_op;
        logic [4:0]    sa;
        logic          alusrc;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
    } id_ex_t;

    // r0 is hard-wired to zero, so a producer targeting it never forwards.
    function automatic logic fwd_hit(input logic regwrite, input logic [RW-1:0] rd,
                                     input logic [RW-1:0] src);
        return regwrite && (rd != {RW{1'b0}}) && (rd == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, forwarding sources, hazard controls and EX-side outputs.
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic          stall;
    logic          flush;
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rs_val;
    logic [DW-1:0] id_rt_val;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [2:0]    id_alu_op;
    logic [4:0]    id_sa;
    logic          id_alusrc;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_memwrite;
    logic          id_memtoreg;
    logic          mem_regwrite;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_fwd;
    logic          wb_regwrite;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    logic [DW-1:0] alu_i1;
    logic [DW-1:0] alu_i2;
    logic [2:0]    alu_op;
    logic [4:0]    alu_sa;
    logic [DW-1:0] ex_store_data;
    logic          ex_valid;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_pc;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_memtoreg;
    logic [1:0]    ex_fwd_a;
    logic [1:0]    ex_fwd_b;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs_val, id_rt_val, id_imm,
               id_rs, id_rt, id_rd, id_alu_op, id_sa, id_alusrc, id_regwrite,
               id_memread, id_memwrite, id_memtoreg, mem_regwrite, mem_rd, mem_fwd,
               wb_regwrite, wb_rd, wb_data,
        input  alu_i1, alu_i2, alu_op, alu_sa, ex_store_data, ex_valid, ex_rd, ex_pc,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_fwd_a, ex_fwd_b
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs_val, id_rt_val, id_imm,
               id_rs, id_rt, id_rd, id_alu_op, id_sa, id_alusrc, id_regwrite,
               id_memread, id_memwrite, id_memtoreg, mem_regwrite, mem_rd, mem_fwd,
               wb_regwrite, wb_rd, wb_data,
        output alu_i1, alu_i2, alu_op, alu_sa, ex_store_data, ex_valid, ex_rd, ex_pc,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_fwd_a, ex_fwd_b
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's bypass selector: EX/MEM result beats MEM/WB data beats the stored value.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] stored,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_fwd,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] value,
    output fwd_sel_e      sel
);

    // Priority select of the youngest in-flight producer of src.
    always_comb begin
        value = stored;
        sel   = FWD_REG;
        if (fwd_hit(mem_regwrite, mem_rd, src)) begin
            value = mem_fwd;
            sel   = FWD_MEM;
        end else if (fwd_hit(wb_regwrite, wb_rd, src)) begin
            value = wb_data;
            sel   = FWD_WB;
        end else begin
            value = stored;
            sel   = FWD_REG;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding feeding the ALU.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    id_ex_t        stage_r;
    id_ex_t        stage_next_s;
    logic [DW-1:0] fwd_a_val_s;
    logic [DW-1:0] fwd_b_val_s;
    fwd_sel_e      fwd_a_sel_s;
    fwd_sel_e      fwd_b_sel_s;

    fwd_mux u_fwd_a (
        .src          (stage_r.rs),
        .stored       (stage_r.rs_val),
        .mem_regwrite (bus.mem_regwrite),
        .mem_rd       (bus.mem_rd),
        .mem_fwd      (bus.mem_fwd),
        .wb_regwrite  (bus.wb_regwrite),
        .wb_rd        (bus.wb_rd),
        .wb_data      (bus.wb_data),
        .value        (fwd_a_val_s),
        .sel          (fwd_a_sel_s)
    );

    fwd_mux u_fwd_b (
        .src          (stage_r.rt),
        .stored       (stage_r.rt_val),
        .mem_regwrite (bus.mem_regwrite),
        .mem_rd       (bus.mem_rd),
        .mem_fwd      (bus.mem_fwd),
        .wb_regwrite  (bus.wb_regwrite),
        .wb_rd        (bus.wb_rd),
        .wb_data      (bus.wb_data),
        .value        (fwd_b_val_s),
        .sel          (fwd_b_sel_s)
    );

    // Next stage contents: bubble on flush; on stall keep everything but refresh the
    // operand values so a producer retiring during the stall is captured.
    always_comb begin
        stage_next_s = stage_r;
        if (bus.flush) begin
            stage_next_s = '0;
        end else if (bus.stall) begin
            stage_next_s.rs_val = fwd_a_val_s;
            stage_next_s.rt_val = fwd_b_val_s;
        end else begin
            stage_next_s.valid    = bus.id_valid;
            stage_next_s.pc       = bus.id_pc;
            stage_next_s.rs_val   = bus.id_rs_val;
            stage_next_s.rt_val   = bus.id_rt_val;
            stage_next_s.imm      = bus.id_imm;
            stage_next_s.rs       = bus.id_rs;
            stage_next_s.rt       = bus.id_rt;
            stage_next_s.rd       = bus.id_rd;
            stage_next_s.alu_op   = bus.id_alu_op;
            stage_next_s.sa       = bus.id_sa;
            stage_next_s.alusrc   = bus.id_alusrc;
            stage_next_s.regwrite = bus.id_regwrite;
            stage_next_s.memread  = bus.id_memread;
            stage_next_s.memwrite = bus.id_memwrite;
            stage_next_s.memtoreg = bus.id_memtoreg;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= stage_next_s;
        end
    end

    assign bus.alu_i1        = fwd_a_val_s;
    assign bus.alu_i2        = stage_r.alusrc ? stage_r.imm : fwd_b_val_s;
    assign bus.alu_op        = stage_r.alu_op;
    assign bus.alu_sa        = stage_r.sa;
    assign bus.ex_store_data = fwd_b_val_s;
    assign bus.ex_valid      = stage_r.valid;
    assign bus.ex_rd         = stage_r.rd;
    assign bus.ex_pc         = stage_r.pc;
    assign bus.ex_regwrite   = stage_r.regwrite;
    assign bus.ex_memread    = stage_r.memread;
    assign bus.ex_memwrite   = stage_r.memwrite;
    assign bus.ex_memtoreg   = stage_r.memtoreg;
    assign bus.ex_fwd_a      = fwd_a_sel_s;
    assign bus.ex_fwd_b      = fwd_b_sel_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural pipeline-register model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid, alusrc, rw, mr, mw, mtr;
        bit [31:0] pc, rsv, rtv, imm;
        bit [4:0] rs, rt, rd, sa;
        bit [2:0] op;
    } model_t;

    model_t m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_fwd(input bit [4:0] r, input bit [31:0] stored,
                                    output bit [31:0] v, output int s);
        v = stored;
        s = 0;
        if (r != 5'd0 && bus.mem_regwrite && bus.mem_rd == r) begin
            v = bus.mem_fwd;
            s = 1;
        end else if (r != 5'd0 && bus.wb_regwrite && bus.wb_rd == r) begin
            v = bus.wb_data;
            s = 2;
        end
    endfunction

    task automatic check_outputs();
        bit [31:0] va, vb;
        int        sa_sel, sb_sel;
        ref_fwd(m.rs, m.rsv, va, sa_sel);
        ref_fwd(m.rt, m.rtv, vb, sb_sel);
        check_eq("alu_i1", bus.alu_i1, va);
        check_eq("alu_i2", bus.alu_i2, m.alusrc ? m.imm : vb);
        check_eq("alu_op", 32'(bus.alu_op), 32'(m.op));
        check_eq("alu_sa", 32'(bus.alu_sa), 32'(m.sa));
        check_eq("store_data", bus.ex_store_data, vb);
        check_eq("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
        check_eq("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        check_eq("ex_pc", bus.ex_pc, m.pc);
        check_eq("ex_regwrite", 32'(bus.ex_regwrite), 32'(m.rw));
        check_eq("ex_memread", 32'(bus.ex_memread), 32'(m.mr));
        check_eq("ex_memwrite", 32'(bus.ex_memwrite), 32'(m.mw));
        check_eq("ex_memtoreg", 32'(bus.ex_memtoreg), 32'(m.mtr));
        check_eq("fwd_a", 32'(bus.ex_fwd_a), sa_sel);
        check_eq("fwd_b", 32'(bus.ex_fwd_b), sb_sel);
    endtask

    // Apply one rising edge, advance the model with the inputs seen at that edge.
    task automatic tick();
        bit [31:0] va, vb;
        int        s;
        ref_fwd(m.rs, m.rsv, va, s);
        ref_fwd(m.rt, m.rtv, vb, s);
        @(posedge clk);
        if (rst || bus.flush) begin
            m = '{default: 0};
        end else if (bus.stall) begin
            m.rsv = va;
            m.rtv = vb;
        end else begin
            m.valid = bus.id_valid;   m.pc = bus.id_pc;         m.rsv = bus.id_rs_val;
            m.rtv = bus.id_rt_val;    m.imm = bus.id_imm;       m.rs = bus.id_rs;
            m.rt = bus.id_rt;         m.rd = bus.id_rd;         m.op = bus.id_alu_op;
            m.sa = bus.id_sa;         m.alusrc = bus.id_alusrc; m.rw = bus.id_regwrite;
            m.mr = bus.id_memread;    m.mw = bus.id_memwrite;   m.mtr = bus.id_memtoreg;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.stall = 1'b0;        bus.flush = 1'b0;        bus.id_valid = 1'b0;
        bus.id_pc = 32'd0;       bus.id_rs_val = 32'd0;   bus.id_rt_val = 32'd0;
        bus.id_imm = 32'd0;      bus.id_rs = 5'd0;        bus.id_rt = 5'd0;
        bus.id_rd = 5'd0;        bus.id_alu_op = 3'd0;    bus.id_sa = 5'd0;
        bus.id_alusrc = 1'b0;    bus.id_regwrite = 1'b0;  bus.id_memread = 1'b0;
        bus.id_memwrite = 1'b0;  bus.id_memtoreg = 1'b0;  bus.mem_regwrite = 1'b0;
        bus.mem_rd = 5'd0;       bus.mem_fwd = 32'd0;     bus.wb_regwrite = 1'b0;
        bus.wb_rd = 5'd0;        bus.wb_data = 32'd0;
    endtask

    task automatic randomize_inputs();
        rst = ($urandom_range(0, 49) == 0);
        bus.flush = ($urandom_range(0, 9) == 0);
        bus.stall = ($urandom_range(0, 4) == 0);
        bus.id_valid = 1'($urandom);      bus.id_pc = $urandom;
        bus.id_rs_val = $urandom;         bus.id_rt_val = $urandom;
        bus.id_imm = $urandom;            bus.id_rs = 5'($urandom_range(0, 7));
        bus.id_rt = 5'($urandom_range(0, 7));
        bus.id_rd = 5'($urandom_range(0, 31));
        bus.id_alu_op = 3'($urandom);     bus.id_sa = 5'($urandom);
        bus.id_alusrc = 1'($urandom);     bus.id_regwrite = 1'($urandom);
        bus.id_memread = 1'($urandom);    bus.id_memwrite = 1'($urandom);
        bus.id_memtoreg = 1'($urandom);   bus.mem_regwrite = 1'($urandom);
        bus.mem_rd = 5'($urandom_range(0, 7));
        bus.mem_fwd = $urandom;           bus.wb_regwrite = 1'($urandom);
        bus.wb_rd = 5'($urandom_range(0, 7));
        bus.wb_data = $urandom;
    endtask

    initial begin
        m = '{default: 0};
        idle();
        @(negedge clk);

        // Reset beats stall, then a plain load.
        rst = 1'b1; bus.stall = 1'b1; bus.id_valid = 1'b1; bus.id_rs_val = 32'h1234;
        bus.id_regwrite = 1'b1; bus.id_pc = 32'h80;
        tick();
        check_outputs();
        check_eq("t1_rst_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("t1_rst_pc", bus.ex_pc, 32'd0);
        idle();
        bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
        bus.id_rs_val = 32'd5; bus.id_rt_val = 32'd7; bus.id_alu_op = ALU_ADD;
        tick();
        check_outputs();
        check_eq("t1_i1", bus.alu_i1, 32'd5);
        check_eq("t1_i2", bus.alu_i2, 32'd7);

        // MEM forward, MEM over WB.
        bus.id_rs = 5'd3; bus.id_rs_val = 32'd9;
        tick();
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3; bus.mem_fwd = 32'h100;
        #1;
        check_eq("t2_i1_mem", bus.alu_i1, 32'h100);
        check_eq("t2_fwd_a", 32'(bus.ex_fwd_a), 32'd1);
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h200;
        #1;
        check_eq("t2_mem_wins", bus.alu_i1, 32'h100);
        check_outputs();

        // WB forward on rt, then r0 never forwards.
        idle();
        bus.id_valid = 1'b1; bus.id_rt = 5'd4; bus.id_rt_val = 32'h11;
        tick();
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hAB;
        #1;
        check_eq("t3_i2_wb", bus.alu_i2, 32'hAB);
        check_eq("t3_fwd_b", 32'(bus.ex_fwd_b), 32'd2);
        idle();
        bus.id_valid = 1'b1; bus.id_rt = 5'd0; bus.id_rt_val = 32'h33;
        tick();
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.mem_fwd = 32'hDEAD;
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hBEEF;
        #1;
        check_eq("t3_r0_i2", bus.alu_i2, 32'h33);
        check_eq("t3_r0_fwd_b", 32'(bus.ex_fwd_b), 32'd0);

        // Immediate operand while store data still forwards.
        idle();
        bus.id_valid = 1'b1; bus.id_alusrc = 1'b1; bus.id_imm = 32'hFFFF_FFFC;
        bus.id_rt = 5'd6; bus.id_rt_val = 32'h1;
        tick();
        bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd6; bus.mem_fwd = 32'h55;
        #1;
        check_eq("t4_i2_imm", bus.alu_i2, 32'hFFFF_FFFC);
        check_eq("t4_store", bus.ex_store_data, 32'h55);
        check_eq("t4_fwd_b", 32'(bus.ex_fwd_b), 32'd1);

        // Stall captures a WB producer that then disappears.
        idle();
        bus.id_valid = 1'b1; bus.id_rs = 5'd8; bus.id_rs_val = 32'h10;
        bus.id_alu_op = ALU_OR; bus.id_pc = 32'h44; bus.id_rd = 5'd9;
        tick();
        bus.stall = 1'b1; bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd8; bus.wb_data = 32'h77;
        bus.id_rs_val = 32'h999; bus.id_alu_op = ALU_XOR; bus.id_pc = 32'h48; bus.id_rd = 5'd2;
        #1;
        check_eq("t5_i1_c1", bus.alu_i1, 32'h77);
        tick();
        bus.wb_regwrite = 1'b0;
        #1;
        check_eq("t5_i1_c2", bus.alu_i1, 32'h77);
        check_eq("t5_op_hold", 32'(bus.alu_op), 32'(ALU_OR));
        check_eq("t5_pc_hold", bus.ex_pc, 32'h44);
        tick();
        check_outputs();
        check_eq("t5_i1_after", bus.alu_i1, 32'h77);

        // Flush beats stall, then fresh load.
        bus.flush = 1'b1; bus.id_regwrite = 1'b1; bus.id_memwrite = 1'b1; bus.id_memread = 1'b1;
        tick();
        check_outputs();
        check_eq("t6_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("t6_regwrite", 32'(bus.ex_regwrite), 32'd0);
        check_eq("t6_memwrite", 32'(bus.ex_memwrite), 32'd0);
        check_eq("t6_op", 32'(bus.alu_op), 32'd0);
        bus.flush = 1'b0; bus.stall = 1'b0; bus.id_pc = 32'h40;
        tick();
        check_outputs();
        check_eq("t6_pc", bus.ex_pc, 32'h40);
        check_eq("t6_valid_back", 32'(bus.ex_valid), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            #1;
            check_outputs();
            tick();
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
